// File: rtl/program_counter.sv
// Program counter sequencer for instruction_fetch: owns fetch_pc/ins_pc, inserts a
// one-cycle bubble on decode redirects, re-addresses the held word on stall, halts at end of memory.
module program_counter #(
  parameter int ADDR_W     = 16,
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jump_valid,
  input  logic [25:0]       jump_target,
  input  logic              jal_valid,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] ins_pc_q;
  logic              fetch_valid_q;
  logic              flush_q;
  logic [ADDR_W-1:0] link_addr_q;
  logic              link_we_q;
  logic              halted_q;
  logic [15:0]       fetch_count_q;

  logic              redir_valid;
  logic              redir_jal;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] br_offset_ext;

  assign br_offset_ext = ADDR_W'($signed(br_offset));

  // Redirect selection: jr over j/jal over branch, only for a real presented instruction
  always_comb begin
    redir_valid = 1'b0;
    redir_jal   = 1'b0;
    redir_pc    = fetch_pc_q;
    if (fetch_valid_q) begin
      if (jr_valid) begin
        redir_valid = 1'b1;
        redir_pc    = jr_target;
      end else if (jump_valid) begin
        redir_valid = 1'b1;
        redir_jal   = jal_valid;
        redir_pc    = jump_target[ADDR_W-1:0];
      end else if (br_taken) begin
        redir_valid = 1'b1;
        redir_pc    = ins_pc_q + ADDR_ONE + br_offset_ext;
      end else begin
        redir_valid = 1'b0;
      end
    end else begin
      redir_valid = 1'b0;
    end
  end

  // Stall re-addresses the presented word so the fetch stage re-latches it
  always_comb begin
    mem_addr = fetch_pc_q;
    case (state_q)
      RUN: begin
        if (stall && fetch_valid_q) begin
          mem_addr = ins_pc_q;
        end else begin
          mem_addr = fetch_pc_q;
        end
      end
      HALT:    mem_addr = LAST_ADDR;
      default: mem_addr = fetch_pc_q;
    endcase
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_ADDR;
      ins_pc_q      <= RESET_ADDR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      link_addr_q   <= '0;
      link_we_q     <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      flush_q   <= 1'b0;
      link_we_q <= 1'b0;
      case (state_q)
        BOOT: begin
          ins_pc_q      <= RESET_ADDR;
          fetch_pc_q    <= RESET_ADDR + ADDR_ONE;
          fetch_valid_q <= 1'b1;
          state_q       <= RUN;
        end
        RUN: begin
          if (fetch_valid_q && !stall) begin
            fetch_count_q <= fetch_count_q + 16'd1;
          end else begin
            fetch_count_q <= fetch_count_q;
          end
          if (redir_valid) begin
            fetch_pc_q    <= redir_pc;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b1;
            state_q       <= BUBBLE;
            if (redir_jal) begin
              link_addr_q <= ins_pc_q + ADDR_ONE;
              link_we_q   <= 1'b1;
            end else begin
              link_addr_q <= link_addr_q;
            end
          end else if (stall) begin
            state_q <= RUN;
          end else if (ins_pc_q == LAST_ADDR) begin
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            state_q       <= HALT;
          end else begin
            ins_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + ADDR_ONE;
          end
        end
        BUBBLE: begin
          ins_pc_q      <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + ADDR_ONE;
          fetch_valid_q <= 1'b1;
          state_q       <= RUN;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ins_pc      = ins_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign link_addr   = link_addr_q;
  assign link_we     = link_we_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/program_counter.md
# program_counter

Upstream sequencer for `instruction_fetch`. It owns the program counter and drives the fetch stage's 16-bit word address `mem_addr`. It also tracks the address of the instruction currently on the fetch output `ins`. Redirects from decode (branch, `j`, `jal`, `jr`) insert a one-cycle bubble. Stalls hold the presented instruction by re-addressing it, and sequential flow halts at the end of instruction memory.

## Interface
- `ADDR_W`, 16: word-address width of `mem_addr`.
- `RESET_PC`, 0: first fetched word address.
- `IMEM_DEPTH`, 32: number of instruction words; last valid address is `IMEM_DEPTH-1`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hold the instruction currently presented.
- `br_taken`  in  1: branch taken for the presented instruction.
- `br_offset`  in  16: signed word offset, relative to `ins_pc+1`.
- `jump_valid`  in  1: `j` or `jal` presented.
- `jump_target`  in  26: absolute target; low `ADDR_W` bits used.
- `jal_valid`  in  1: qualifies `jump_valid` as `jal`.
- `jr_valid`  in  1: `jr` presented.
- `jr_target`  in  16: register-sourced absolute target.
- `mem_addr`  out  16: word address to `instruction_fetch`.
- `ins_pc`  out  16: address of the word currently on `ins`.
- `fetch_valid`  out  1: `ins`/`ins_pc` hold a real instruction.
- `flush`  out  1: one-cycle pulse; the word currently on `ins` is wrong-path.
- `link_addr`  out  16: `jal` return address.
- `link_we`  out  1: one-cycle write strobe for `link_addr`.
- `halted`  out  1: sequential flow ran past `IMEM_DEPTH-1`.
- `fetch_count`  out  16: count of instructions accepted.

## Operation
- Internal registers:
  - `fetch_pc`: next address to fetch.
  - `ins_pc`.
  - state in {BOOT, RUN, BUBBLE, HALT}.
- `mem_addr` is combinational:
  - `ins_pc` when `stall && fetch_valid` in RUN. This makes the fetch re-latch the same word, so `ins` is held.
  - `IMEM_DEPTH-1` in HALT.
  - `fetch_pc` otherwise.
- Redirect inputs are qualified by `fetch_valid` and ignored otherwise.
- Redirect priority: `jr_valid` > `jump_valid` > `br_taken`. Any redirect overrides `stall`.
- Targets, all modulo 2^16:
  - jr: `jr_target`.
  - jump: `jump_target[15:0]`.
  - branch: `ins_pc + 1 + sext(br_offset)`.
- BOOT (reset state): at the first edge, `ins_pc<=RESET_PC`, `fetch_pc<=RESET_PC+1`, `fetch_valid<=1`, next state RUN.
- RUN, with priority:
  1. Redirect: `fetch_pc<=target`, `fetch_valid<=0`, `flush<=1`, next state BUBBLE. If `jal`, also `link_addr<=ins_pc+1` and `link_we<=1`.
  2. `stall`: all registers hold.
  3. `ins_pc==IMEM_DEPTH-1`: `fetch_valid<=0`, `halted<=1`, next state HALT.
  4. Otherwise: `ins_pc<=fetch_pc`, `fetch_pc<=fetch_pc+1`.
- BUBBLE: `ins_pc<=fetch_pc`, `fetch_pc<=fetch_pc+1`, `fetch_valid<=1`, next state RUN. `stall` is ignored because `fetch_valid` is 0.
- HALT: all outputs hold; exit only through `rst_n`.
- `fetch_count` increments on each edge where `fetch_valid && !stall` in RUN, redirecting instructions included. It wraps at 2^16.
- `flush` and `link_we` are high for exactly one cycle.

## Timing
- Reset values while `rst_n=0`:
  - `mem_addr=RESET_PC`, `ins_pc=RESET_PC`.
  - `fetch_valid=0`, `flush=0`, `link_we=0`, `halted=0`.
  - `link_addr=0`, `fetch_count=0`.
  - state BOOT.
- `fetch_valid` is 1 one edge after reset release, with `ins_pc=RESET_PC`.
- Sequential throughput is one instruction per cycle.
- Redirect penalty is exactly one bubble cycle. The target is presented two edges after the redirect edge.
- Stall:
  - The `mem_addr` change is same-cycle (combinational from `stall`).
  - `ins`, `ins_pc` and `fetch_pc` are unchanged across every stalled edge.
- Redirect and end-of-memory in the same cycle: redirect wins and `halted` stays 0.
- Reset asserted mid-operation, including in BUBBLE or HALT, forces the reset values immediately (asynchronous).

## Test plan
- **Reset and sequential flow:** release `rst_n` with no stimulus → `mem_addr` 0 during reset; `ins_pc` goes 0,1,2,3 on successive cycles from edge 1; `fetch_valid=1`; `fetch_count` increments by 1 per cycle.
- **Stall hold:** assert `stall` for 2 cycles while `ins_pc=3` → `mem_addr=3`, `ins` unchanged, `ins_pc=3` for 3 cycles, then 4; `fetch_count` does not advance while stalled.
- **Backward branch:** at `ins_pc=14`, drive `br_taken=1`, `br_offset=-3` → `flush` high 1 cycle, `fetch_valid=0` 1 cycle, then `ins_pc=12`, 13, …
- **jal:** at `ins_pc=22`, drive `jump_valid=1`, `jal_valid=1`, `jump_target=5` → `link_we` pulses with `link_addr=23`; one bubble; then `ins_pc=5`.
- **Priority:** at `ins_pc=7`, drive `jr_valid=1`, `jr_target=2`, `br_taken=1`, `stall=1` together → jr wins; bubble; then `ins_pc=2`. Redirect inputs asserted during the bubble are ignored.
- **Halt and reset:** `IMEM_DEPTH=32`, sequential run to `ins_pc=31` → next edge `halted=1`, `fetch_valid=0`, `mem_addr=31`, outputs hold. Then pulse `rst_n` low → `ins_pc=0`, `halted=0`, flow restarts.
